dense_layer_sequencer: RTL and testbench



---
 rtl/dense_layer_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dense_layer_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_sequencer.sv
// One fully connected layer over a single shared 16x16 signed MAC.
// Each neuron fetches its bias and then N_IN weights, and finalises with ReLU and saturation.
module dense_layer_sequencer #(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned DW    = 16,
  parameter int unsigned FRAC  = 10,
  parameter int unsigned AW    = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [N_IN*DW-1:0]    x,
  output logic                  w_rd,
  output logic [AW-1:0]         w_addr,
  input  logic [DW-1:0]         w_data,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [N_OUT*DW-1:0]   y,
  output logic                  busy
);

  localparam int unsigned LW       = $clog2(N_IN + 1);
  localparam int unsigned NW       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned AccW     = 40;
  localparam int unsigned BiasBase = N_OUT * N_IN;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StOut} state_e;

  state_e              state_q, state_d;
  logic                up_q;
  logic [N_IN*DW-1:0]  x_q;
  logic                x_ld;
  // Issue counters: l == 0 addresses the bias, l == i+1 addresses weight i.
  logic [NW-1:0]       n_q, n_d;
  logic [LW-1:0]       l_q, l_d;
  logic                w_rd_q, w_rd_d;
  logic [AW-1:0]       w_addr_q, w_addr_d;
  // Tag of the datum arriving on w_data this cycle.
  logic                t_vld_q;
  logic [NW-1:0]       t_n_q;
  logic [LW-1:0]       t_l_q;
  logic signed [AccW-1:0] acc_q;
  logic [N_OUT*DW-1:0] y_q;

  function automatic logic [AW-1:0] addr_of(input logic [NW-1:0] n, input logic [LW-1:0] l);
    if (l == '0) begin
      return AW'(BiasBase + 32'(n));
    end
    return AW'(32'(n) * N_IN + 32'(l) - 32'd1);
  endfunction

  assign x_ready = (state_q == StIdle) && up_q;
  assign busy    = (state_q != StIdle);
  assign y_valid = (state_q == StOut);
  assign w_rd    = w_rd_q;
  assign w_addr  = w_addr_q;
  assign y       = y_q;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    l_d      = l_q;
    w_rd_d   = 1'b0;
    w_addr_d = w_addr_q;
    x_ld     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (x_valid && x_ready) begin
          x_ld     = 1'b1;
          n_d      = '0;
          l_d      = '0;
          w_rd_d   = 1'b1;
          w_addr_d = AW'(BiasBase);
          state_d  = StFetch;
        end
      end
      StFetch: begin
        if (l_q == LW'(N_IN)) begin
          if (n_q == NW'(N_OUT - 1)) begin
            state_d = StDrain;
          end else begin
            n_d    = n_q + NW'(1);
            l_d    = '0;
            w_rd_d = 1'b1;
          end
        end else begin
          l_d    = l_q + LW'(1);
          w_rd_d = 1'b1;
        end
        if (w_rd_d) begin
          w_addr_d = addr_of(n_d, l_d);
        end
      end
      StDrain: state_d = StOut;
      StOut: begin
        if (y_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      up_q     <= 1'b0;
      n_q      <= '0;
      l_q      <= '0;
      w_rd_q   <= 1'b0;
      w_addr_q <= '0;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      up_q     <= 1'b1;
      n_q      <= n_d;
      l_q      <= l_d;
      w_rd_q   <= w_rd_d;
      w_addr_q <= w_addr_d;
      if (x_ld) begin
        x_q <= x;
      end
    end
  end

  logic [LW-1:0]          lane_idx;
  logic signed [DW-1:0]   w_s;
  logic signed [DW-1:0]   x_lane;
  logic signed [2*DW-1:0] prod;
  logic signed [AccW-1:0] bias_ext;
  logic signed [AccW-1:0] acc_nxt;
  logic signed [AccW-1:0] shifted;
  logic [DW-1:0]          res;

  always_comb begin
    lane_idx = (t_l_q == '0) ? '0 : t_l_q - LW'(1);
    w_s      = w_data;
    x_lane   = x_q[DW*32'(lane_idx) +: DW];
    prod     = w_s * x_lane;
    bias_ext = {{(AccW-DW){w_data[DW-1]}}, w_data} <<< FRAC;
    if (t_l_q == '0) begin
      acc_nxt = bias_ext;
    end else begin
      acc_nxt = acc_q + {{(AccW-2*DW){prod[2*DW-1]}}, prod};
    end
    shifted = acc_nxt >>> FRAC;
    // ReLU absorbs the negative saturation bound.
    if (shifted[AccW-1]) begin
      res = '0;
    end else if (|shifted[AccW-2:DW-1]) begin
      res = {1'b0, {(DW-1){1'b1}}};
    end else begin
      res = shifted[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_vld_q <= 1'b0;
      t_n_q   <= '0;
      t_l_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      t_vld_q <= w_rd_q;
      t_n_q   <= n_q;
      t_l_q   <= l_q;
      if (t_vld_q) begin
        acc_q <= acc_nxt;
        if (t_l_q == LW'(N_IN)) begin
          y_q[DW*32'(t_n_q) +: DW] <= res;
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Randomised and directed bench for dense_layer_sequencer against an integer reference model.
module tb_dense_layer_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         x_valid = 1'b0;
  logic         x_ready;
  logic [127:0] x = '0;
  logic         w_rd;
  logic [6:0]   w_addr;
  logic [15:0]  w_data = '0;
  logic         y_valid;
  logic         y_ready = 1'b0;
  logic [127:0] y;
  logic         busy;

  logic [15:0]  mem [0:127];
  int           tests = 0;
  int           fails = 0;

  dense_layer_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .x      (x),
    .w_rd   (w_rd),
    .w_addr (w_addr),
    .w_data (w_data),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .y      (y),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory: data valid the cycle after the read strobe.
  always @(posedge clk) if (w_rd) w_data <= mem[w_addr];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] xv);
    logic [127:0] out;
    longint acc, r;
    out = '0;
    for (int j = 0; j < 8; j++) begin
      acc = longint'($signed(mem[64+j])) * 1024;
      for (int i = 0; i < 8; i++)
        acc += longint'($signed(mem[j*8+i])) * longint'($signed(xv[16*i +: 16]));
      r = acc >>> 10;
      if (r < 0) r = 0;
      if (r > 32767) r = 32767;
      out[16*j +: 16] = r[15:0];
    end
    return out;
  endfunction

  // Issue k of the fetch: neuron k/9, bias first then weights 0..7.
  function automatic logic [6:0] exp_addr(input int k);
    int n, l;
    n = k / 9;
    l = k % 9;
    return (l == 0) ? 7'(64 + n) : 7'(n*8 + l - 1);
  endfunction

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_w_rd", w_rd, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y", y, 0);
    chk("rst_x_ready", x_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_release_x_ready", x_ready, 0);
    @(negedge clk);
    chk("rst_after_edge_x_ready", x_ready, 1);
  endtask

  task automatic run_vec(input logic [127:0] xv, input int hold, input int abort_at);
    logic [127:0] exp, yh;
    int wn;
    exp = model(xv);
    wn = 0;
    while (!x_ready && wn < 20) begin
      @(negedge clk);
      wn++;
    end
    chk("x_ready_wait", x_ready, 1);
    if (!x_ready) return;
    x_valid = 1'b1;
    x = xv;
    @(negedge clk);
    x = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 73; c++) begin
      if (c == abort_at) begin
        x_valid = 1'b0;
        do_reset();
        return;
      end
      chk("w_rd", w_rd, c <= 72);
      if (c <= 72) chk("w_addr", w_addr, exp_addr(c - 1));
      chk("y_valid_early", y_valid, 0);
      chk("busy_run", busy, 1);
      chk("x_ready_run", x_ready, 0);
      x_valid = (c < 72) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    chk("y_valid_latency", y_valid, 1);
    chk("y_model", y, exp);
    yh = y;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_y", y, yh);
      chk("hold_y_valid", y_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_x_ready", x_ready, 0);
      chk("hold_w_rd", w_rd, 0);
    end
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    chk("post_hs_x_ready", x_ready, 1);
    chk("post_hs_y_valid", y_valid, 0);
    chk("post_hs_busy", busy, 0);
  endtask

  task automatic pin(input string name, input logic [127:0] xv, input logic [127:0] lit,
                     input int hold);
    chk({name, "_model"}, model(xv), lit);
    run_vec(xv, hold, 0);
    chk({name, "_y"}, y, lit);
  endtask

  task automatic fill(input logic [15:0] w, input logic [15:0] b);
    for (int a = 0; a < 64; a++) mem[a] = w;
    for (int a = 64; a < 128; a++) mem[a] = b;
  endtask

  logic [127:0] xv, lit;

  initial begin
    fill(16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    chk("reset_x_ready", x_ready, 0);
    chk("reset_w_rd", w_rd, 0);
    chk("reset_w_addr", w_addr, 0);
    chk("reset_y", y, 0);
    chk("reset_y_valid", y_valid, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    #1 chk("release_x_ready", x_ready, 0);
    @(negedge clk);
    chk("first_edge_x_ready", x_ready, 1);

    fill(16'h0400, 16'h0000);
    xv = {8{16'h0400}};
    pin("ones", xv, {8{16'h2000}}, 10);

    xv[16*6 +: 16] = 16'h0000;
    pin("lane6_zero", xv, {8{16'h1C00}}, 0);

    for (int a = 0; a < 64; a++) mem[a] = 16'($urandom);
    for (int j = 0; j < 8; j++) begin
      mem[64+j] = 16'(j * 16'h0400);
      lit[16*j +: 16] = 16'(j * 16'h0400);
    end
    pin("bias_only", '0, lit, 0);

    fill(16'hFC00, 16'h0000);
    pin("relu", {8{16'h0400}}, '0, 0);

    fill(16'h7FFF, 16'h7FFF);
    pin("saturate", {8{16'h7FFF}}, {8{16'h7FFF}}, 0);

    fill(16'h0000, 16'h0000);
    mem[0] = 16'h8000;
    mem[8] = 16'h0400;
    lit = '0;
    lit[31:16] = 16'h7FFF;
    pin("neg_weight", {8{16'h7FFF}}, lit, 0);

    fill(16'h0400, 16'h0000);
    run_vec({8{16'h0400}}, 0, 30);
    pin("after_reset", {8{16'h0400}}, {8{16'h2000}}, 0);

    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);
      xv = {$urandom, $urandom, $urandom, $urandom};
      run_vec(xv, int'($urandom_range(0, 3)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
